// File: rtl/crsr_mem_arb_if.sv
// Bundle of the cursor, host and RAM-side signals around the cursor image RAM arbiter.
// The slave modport is the arbiter's view; the master modport is its surroundings.
interface crsr_mem_arb_if;
    logic        crsr_req;
    logic [7:0]  crsr_addr;
    logic        crsr_flush;
    logic [31:0] crsr_data;
    logic        crsr_hit;
    logic        crsr_stall;

    logic        host_req;
    logic        host_we;
    logic [7:0]  host_addr;
    logic [31:0] host_wdata;
    logic        host_ack;
    logic [31:0] host_rdata;

    logic        ram_en;
    logic        ram_we;
    logic [7:0]  ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    modport slave (
        input  crsr_req, crsr_addr, crsr_flush,
        output crsr_data, crsr_hit, crsr_stall,
        input  host_req, host_we, host_addr, host_wdata,
        output host_ack, host_rdata,
        output ram_en, ram_we, ram_addr, ram_wdata,
        input  ram_rdata
    );

    modport master (
        output crsr_req, crsr_addr, crsr_flush,
        input  crsr_data, crsr_hit, crsr_stall,
        output host_req, host_we, host_addr, host_wdata,
        input  host_ack, host_rdata,
        input  ram_en, ram_we, ram_addr, ram_wdata,
        output ram_rdata
    );
endinterface

// File: rtl/crsr_mem_arb.sv
// Cursor image RAM arbiter with a one-word cursor cache. Cursor misses take priority;
// a saturating wait counter forces a host grant after MAXWAIT denials.
module crsr_mem_arb #(
    parameter int unsigned MAXWAIT = 8
) (
    input logic           clk,
    input logic           reset,
    crsr_mem_arb_if.slave bus
);
    localparam int unsigned     CntW   = $clog2(MAXWAIT + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(MAXWAIT);

    typedef enum logic [2:0] {StIdle, StCfill, StHwack, StHrdata, StHrack} state_e;

    state_e          state_q;
    logic            tag_valid_q;
    logic [7:0]      tag_q;
    logic [7:0]      fill_addr_q;
    logic [31:0]     word_q;
    logic [31:0]     host_rdata_q;
    logic            host_ack_q;
    logic [CntW-1:0] wait_cnt_q;

    logic hit;
    logic cmiss;
    logic host_force;
    logic host_win;
    logic crsr_win;

    assign hit        = bus.crsr_req & tag_valid_q & (tag_q == bus.crsr_addr);
    assign cmiss      = bus.crsr_req & ~hit;
    assign host_force = bus.host_req & (wait_cnt_q == MaxCnt);
    assign host_win   = (state_q == StIdle) & bus.host_req & (host_force | ~cmiss);
    assign crsr_win   = (state_q == StIdle) & cmiss & ~host_force;

    assign bus.crsr_hit   = hit;
    assign bus.crsr_stall = cmiss;
    assign bus.crsr_data  = word_q;
    assign bus.host_ack   = host_ack_q;
    assign bus.host_rdata = host_rdata_q;

    // The RAM port is only ever driven from IDLE, in the cycle of the grant.
    assign bus.ram_en    = ~reset & (host_win | crsr_win);
    assign bus.ram_we    = ~reset & host_win & bus.host_we;
    assign bus.ram_addr  = host_win ? bus.host_addr : bus.crsr_addr;
    assign bus.ram_wdata = bus.host_wdata;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            tag_valid_q  <= 1'b0;
            tag_q        <= '0;
            fill_addr_q  <= '0;
            word_q       <= '0;
            host_rdata_q <= '0;
            host_ack_q   <= 1'b0;
            wait_cnt_q   <= '0;
        end else begin
            host_ack_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (host_win) begin
                        wait_cnt_q <= '0;
                        if (bus.host_we) begin
                            state_q    <= StHwack;
                            host_ack_q <= 1'b1;
                            // Keep the cached word coherent with the RAM write.
                            if (tag_valid_q && (tag_q == bus.host_addr)) begin
                                word_q <= bus.host_wdata;
                            end
                        end else begin
                            state_q <= StHrdata;
                        end
                    end else if (crsr_win) begin
                        state_q     <= StCfill;
                        fill_addr_q <= bus.crsr_addr;
                        if (bus.host_req && (wait_cnt_q != MaxCnt)) begin
                            wait_cnt_q <= wait_cnt_q + CntW'(1);
                        end
                    end
                end
                StCfill: begin
                    state_q <= StIdle;
                    if (!bus.crsr_flush) begin
                        word_q      <= bus.ram_rdata;
                        tag_q       <= fill_addr_q;
                        tag_valid_q <= 1'b1;
                    end
                end
                StHwack: state_q <= StIdle;
                StHrdata: begin
                    state_q      <= StHrack;
                    host_rdata_q <= bus.ram_rdata;
                    host_ack_q   <= 1'b1;
                end
                StHrack: state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
            if (bus.crsr_flush) begin
                tag_valid_q <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_crsr_mem_arb.sv
// Bench for crsr_mem_arb: directed scenarios with literal expectations, then random traffic,
// all checked every cycle against a timestamp-based reference model.
module tb_crsr_mem_arb;
    localparam int unsigned MAXWAIT = 8;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    crsr_mem_arb_if bus ();

    crsr_mem_arb #(.MAXWAIT(MAXWAIT)) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    // Behavioural RAM; unwritten words read back a fixed address-derived pattern.
    logic [31:0] ram_mem [256];
    bit          ram_wr  [256];

    function automatic logic [31:0] init_word(logic [7:0] a);
        return {a, ~a, a ^ 8'h5a, 8'hc3};
    endfunction

    always @(posedge clk) begin
        if (bus.ram_en) begin
            if (bus.ram_we) begin
                ram_mem[bus.ram_addr] <= bus.ram_wdata;
                ram_wr[bus.ram_addr]  <= 1'b1;
            end else begin
                bus.ram_rdata <= ram_wr[bus.ram_addr] ? ram_mem[bus.ram_addr]
                                                      : init_word(bus.ram_addr);
            end
        end
    end

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    int n_reads = 0;

    // Reference model: cache contents, RAM contents and event times of the job in flight.
    logic [31:0] ref_mem [256];
    bit          ref_wr  [256];
    bit          m_valid = 1'b0;
    logic [7:0]  m_tag   = '0;
    logic [31:0] m_word  = '0;
    logic [31:0] m_rdata = '0;
    int          m_wait  = 0;
    int          free_at = 0;
    int          ack_at  = -1;
    int          fill_end = -1;
    int          rd_end  = -1;
    logic [7:0]  fill_a  = '0;
    logic [31:0] rd_val  = '0;
    bit          m_acked = 1'b0;

    function automatic logic [31:0] ref_word(logic [7:0] a);
        return ref_wr[a] ? ref_mem[a] : init_word(a);
    endfunction

    task automatic check(string name, logic [31:0] got, logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic model_cycle();
        bit         hit;
        bit         cmiss;
        bit         en;
        bit         we;
        logic [7:0] addr;
        hit = bus.crsr_req && m_valid && (m_tag == bus.crsr_addr);
        check("crsr_hit", bus.crsr_hit, hit);
        check("crsr_stall", bus.crsr_stall, bus.crsr_req && !hit);
        if (hit) check("crsr_data", bus.crsr_data, m_word);
        m_acked = (cyc == ack_at);
        check("host_ack", bus.host_ack, m_acked);
        check("host_rdata", bus.host_rdata, m_rdata);
        if (bus.ram_en && !bus.ram_we) n_reads++;
        en   = 1'b0;
        we   = 1'b0;
        addr = '0;
        if (reset) begin
            check("ram_en_in_reset", bus.ram_en, 0);
            check("ram_we_in_reset", bus.ram_we, 0);
            m_valid  = 1'b0;
            m_tag    = '0;
            m_word   = '0;
            m_rdata  = '0;
            m_wait   = 0;
            free_at  = cyc + 1;
            ack_at   = -1;
            fill_end = -1;
            rd_end   = -1;
        end else begin
            if (cyc >= free_at) begin
                cmiss = bus.crsr_req && !hit;
                if (bus.host_req && (m_wait >= int'(MAXWAIT) || !cmiss)) begin
                    en     = 1'b1;
                    we     = bus.host_we;
                    addr   = bus.host_addr;
                    m_wait = 0;
                    if (we) begin
                        ack_at  = cyc + 1;
                        free_at = cyc + 2;
                    end else begin
                        rd_val  = ref_word(addr);
                        rd_end  = cyc + 1;
                        ack_at  = cyc + 2;
                        free_at = cyc + 3;
                    end
                end else if (cmiss) begin
                    en       = 1'b1;
                    addr     = bus.crsr_addr;
                    fill_a   = addr;
                    fill_end = cyc + 1;
                    free_at  = cyc + 2;
                    if (bus.host_req && m_wait < int'(MAXWAIT)) m_wait++;
                end
            end
            check("ram_en", bus.ram_en, en);
            check("ram_we", bus.ram_we, we);
            if (en) check("ram_addr", bus.ram_addr, addr);
            if (we) check("ram_wdata", bus.ram_wdata, bus.host_wdata);
            if (cyc == fill_end && !bus.crsr_flush) begin
                m_word  = ref_word(fill_a);
                m_tag   = fill_a;
                m_valid = 1'b1;
            end
            if (cyc == rd_end) m_rdata = rd_val;
            if (we) begin
                if (m_valid && m_tag == addr) m_word = bus.host_wdata;
                ref_mem[addr] = bus.host_wdata;
                ref_wr[addr]  = 1'b1;
            end
            if (bus.crsr_flush) m_valid = 1'b0;
        end
    endtask

    // Inputs are driven just after the falling edge; outputs are sampled 1-2 ns later.
    task automatic step();
        #1;
        model_cycle();
        @(negedge clk);
        cyc++;
    endtask

    task automatic host_txn(input bit we, input logic [7:0] a, input logic [31:0] d,
                            input bit alt, output int grant_lat, output int ack_lat);
        grant_lat      = -1;
        ack_lat        = -1;
        bus.host_req   = 1'b1;
        bus.host_we    = we;
        bus.host_addr  = a;
        bus.host_wdata = d;
        for (int i = 0; i < 40 && ack_lat < 0; i++) begin
            if (alt) begin
                bus.crsr_req  = 1'b1;
                bus.crsr_addr = 8'((i >> 1) & 1);
            end
            #1;
            if (grant_lat < 0 && bus.ram_en && bus.ram_we == we && bus.ram_addr == a) begin
                grant_lat = i;
            end
            if (bus.host_ack) ack_lat = i;
            step();
        end
        bus.host_req = 1'b0;
        if (alt) bus.crsr_req = 1'b0;
        check("host_ack_seen", ack_lat >= 0, 1);
    endtask

    initial begin
        int g;
        int a;
        int r0;
        int stalls;
        bit host_active;

        reset          = 1'b1;
        bus.crsr_req   = 1'b0;
        bus.crsr_addr  = '0;
        bus.crsr_flush = 1'b0;
        bus.host_req   = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
        @(negedge clk);
        #1;
        check("reset_ack", bus.host_ack, 0);
        check("reset_rdata", bus.host_rdata, 0);
        check("reset_ram_en", bus.ram_en, 0);
        step();
        step();
        reset = 1'b0;

        // Host write, then cursor miss/fill and a run of hits on the same word.
        host_txn(1'b1, 8'h05, 32'ha5a5_0f0f, 1'b0, g, a);
        check("wr_grant_lat", g, 0);
        check("wr_ack_lat", a, 1);
        bus.crsr_req  = 1'b1;
        bus.crsr_addr = 8'h05;
        r0     = n_reads;
        stalls = 0;
        #1 check("miss_stall_t0", bus.crsr_stall, 1);
        step();
        #1 check("miss_stall_t1", bus.crsr_stall, 1);
        step();
        #1 check("fill_hit_t2", bus.crsr_hit, 1);
        check("fill_data", bus.crsr_data, 32'ha5a5_0f0f);
        for (int i = 0; i < 16; i++) begin
            stalls += int'(bus.crsr_stall);
            step();
        end
        check("hit_run_reads", n_reads - r0, 1);
        check("hit_run_stalls", stalls, 0);
        bus.crsr_req = 1'b0;

        // Starvation bound: cursor misses on every IDLE cycle while a host read waits.
        host_txn(1'b1, 8'h10, 32'hcafe_f00d, 1'b0, g, a);
        host_txn(1'b0, 8'h10, 32'h0, 1'b1, g, a);
        check("starve_grant_bound", g >= 0 && g <= 2 * int'(MAXWAIT), 1);
        check("starve_ack_lat", a - g, 2);
        check("starve_rdata", bus.host_rdata, 32'hcafe_f00d);

        // Coherence: write to the cached address updates the word without a refill.
        bus.crsr_req  = 1'b1;
        bus.crsr_addr = 8'h20;
        step();
        step();
        r0 = n_reads;
        bus.host_req   = 1'b1;
        bus.host_we    = 1'b1;
        bus.host_addr  = 8'h20;
        bus.host_wdata = 32'h1234_5678;
        #1 check("coh_write_grant", bus.ram_we, 1);
        step();
        #1 check("coh_hit", bus.crsr_hit, 1);
        check("coh_data", bus.crsr_data, 32'h1234_5678);
        step();
        bus.host_req = 1'b0;
        #1 check("coh_no_refill", bus.ram_en, 0);
        step();
        check("coh_reads", n_reads - r0, 0);

        // Flush during the fill cycle discards the fill and forces a refetch.
        bus.crsr_addr = 8'h30;
        #1 check("flush_miss", bus.ram_en, 1);
        step();
        bus.crsr_flush = 1'b1;
        step();
        bus.crsr_flush = 1'b0;
        #1 check("flush_rehit", bus.crsr_hit, 0);
        check("flush_refetch_addr", bus.ram_addr, 8'h30);
        check("flush_refetch_en", bus.ram_en, 1);
        step();
        step();
        #1 check("flush_refill_hit", bus.crsr_hit, 1);

        // Reset in the read-data cycle aborts the read with no ack.
        bus.host_req  = 1'b1;
        bus.host_we   = 1'b0;
        bus.host_addr = 8'h40;
        #1 check("rst_rd_grant", bus.ram_en && !bus.ram_we && bus.ram_addr == 8'h40, 1);
        step();
        reset = 1'b1;
        #1 check("rst_no_strobe", bus.ram_en, 0);
        step();
        reset        = 1'b0;
        bus.host_req = 1'b0;
        #1 check("rst_ack", bus.host_ack, 0);
        check("rst_rdata", bus.host_rdata, 0);
        check("rst_tag_valid", bus.crsr_hit, 0);
        step();
        #1 check("rst_no_late_ack", bus.host_ack, 0);
        step();

        // Random traffic against the model.
        host_active = 1'b0;
        for (int i = 0; i < 4000; i++) begin
            if (reset) host_active = 1'b0;
            reset = ($urandom_range(0, 299) == 0);
            if (host_active && m_acked) host_active = 1'b0;
            if (!host_active && $urandom_range(0, 2) == 0) begin
                host_active    = 1'b1;
                bus.host_we    = 1'($urandom_range(0, 1));
                bus.host_addr  = 8'($urandom_range(0, 7));
                bus.host_wdata = $urandom;
            end
            bus.host_req   = host_active;
            bus.crsr_req   = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 2) == 0) bus.crsr_addr = 8'($urandom_range(0, 7));
            bus.crsr_flush = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
